fp_pack_round_pipe: RTL and testbench

//  Multi-lane, parametrised FP result packer for the adder-tree datapath. Takes unrounded

---
 rtl/fp_pack_pkg.sv | 31 +++
 rtl/fp_round_lane.sv | 93 +++++++++
 rtl/fp_pack_round_pipe.sv | 146 ++++++++++++++
 tb/tb_fp_pack_round_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pack_pkg.sv
// Shared widths, rounding-mode encodings and special-value bit patterns
// for the FP result packer. Each pattern excludes the sign bit; callers
// prepend the sign and keep the low EXP_W+MANT_W bits.
package fp_pack_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_MANT_W = 23;
    localparam int DEF_LANES  = 4;

    // Widest magnitude the pattern helpers can describe.
    localparam int PAT_W = 64;

    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    // All-ones exponent, zero fraction: infinity magnitude.
    function automatic logic [PAT_W-1:0] inf_pattern(input int exp_w, input int mant_w);
        return ((64'd1 << exp_w) - 64'd1) << mant_w;
    endfunction

    // Canonical quiet NaN: all-ones exponent, fraction MSB set.
    function automatic logic [PAT_W-1:0] qnan_pattern(input int exp_w, input int mant_w);
        return inf_pattern(exp_w, mant_w) | (64'd1 << (mant_w - 1));
    endfunction

    // Largest finite magnitude: exponent all-ones minus one, fraction all ones.
    function automatic logic [PAT_W-1:0] max_finite_pattern(input int exp_w, input int mant_w);
        return (((64'd1 << exp_w) - 64'd2) << mant_w) | ((64'd1 << mant_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_round_lane.sv
// Combinational per-lane rounding, range handling and IEEE-754 packing.
// Sits between the S1 and S2 registers of fp_pack_round_pipe.
module fp_round_lane
    import fp_pack_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MANT_W = DEF_MANT_W
) (
    input  logic                     rnd_mode,
    input  logic                     sign,
    input  logic [EXP_W+1:0]         exp,
    input  logic [MANT_W+2:0]        mant,
    input  logic                     zero,
    input  logic                     inf,
    input  logic                     nan,
    output logic [EXP_W+MANT_W:0]    word,
    output logic                     set_ovf,
    output logic                     set_unf,
    output logic                     set_inx,
    output logic                     set_nan
);

    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int XW = EXP_W + 2;
    localparam int MW = MANT_W + 3;

    localparam logic [PAT_W-1:0] INF_FULL  = inf_pattern(EXP_W, MANT_W);
    localparam logic [PAT_W-1:0] QNAN_FULL = qnan_pattern(EXP_W, MANT_W);
    localparam logic [PAT_W-1:0] MAXF_FULL = max_finite_pattern(EXP_W, MANT_W);
    localparam logic [W-2:0]     INF_MAG   = INF_FULL[W-2:0];
    localparam logic [W-2:0]     QNAN_MAG  = QNAN_FULL[W-2:0];
    localparam logic [W-2:0]     MAXF_MAG  = MAXF_FULL[W-2:0];

    // Smallest post-round exponent that no longer fits a finite encoding.
    localparam logic [XW-1:0]    EXP_TOP   = {2'b00, {EXP_W{1'b1}}};

    logic                lsb;
    logic                guard;
    logic                sticky;
    logic                inc;
    logic                frac_carry;
    logic [MANT_W-1:0]   frac_r;
    logic                carry;
    logic [XW:0]         exp_r;
    logic                ovf_c;
    logic                unf_c;

    assign lsb    = mant[2];
    assign guard  = mant[1];
    assign sticky = mant[0];
    assign inc    = (rnd_mode == RND_RNE) & guard & (sticky | lsb);

    // Rounding the fraction alone: a carry out of the fraction propagates
    // through the hidden bit, so the significand overflows only when the
    // hidden bit is set. The wrapped fraction is then zero as required.
    assign {frac_carry, frac_r} = {1'b0, mant[MW-2:2]} + {{MANT_W{1'b0}}, inc};
    assign carry = frac_carry & mant[MW-1];

    // One extra sign-extended bit so exp+1 can never wrap.
    assign exp_r = {exp[XW-1], exp} + {{XW{1'b0}}, carry};
    assign ovf_c = ~exp_r[XW] & (exp_r[XW-1:0] >= EXP_TOP);
    assign unf_c = exp_r[XW] | (exp_r == '0);

    // Special-case priority, range clamping and per-lane exception flags.
    always_comb begin
        // NOTE: every output gets a default before the if-chain; a path that
        // leaves one unassigned would infer a latch.
        word    = {sign, exp_r[EXP_W-1:0], frac_r};
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_inx = 1'b0;
        set_nan = 1'b0;
        if (nan) begin
            word    = {1'b0, QNAN_MAG};
            set_nan = 1'b1;
        end else if (inf) begin
            word = {sign, INF_MAG};
        end else if (zero) begin
            word = {sign, {(W-1){1'b0}}};
        end else if (ovf_c) begin
            word    = (rnd_mode == RND_RNE) ? {sign, INF_MAG} : {sign, MAXF_MAG};
            set_ovf = 1'b1;
            set_inx = 1'b1;
        end else if (unf_c) begin
            word    = {sign, {(W-1){1'b0}}};
            set_unf = 1'b1;
            set_inx = 1'b1;
        end else begin
            set_inx = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_pack_round_pipe.sv
// Multi-lane FP result packer: S1 captures the normalised inputs, the
// per-lane rounders feed S2 which holds the packed words. A single global
// stall freezes both stages; exception flags are sticky and accumulate
// only on output handshakes.
module fp_pack_round_pipe
    import fp_pack_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MANT_W = DEF_MANT_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                rnd_mode,
    input  logic [LANES-1:0]                    in_sign,
    input  logic [LANES*(EXP_W+2)-1:0]          in_exp,
    input  logic [LANES*(MANT_W+3)-1:0]         in_mant,
    input  logic [LANES-1:0]                    in_zero,
    input  logic [LANES-1:0]                    in_inf,
    input  logic [LANES-1:0]                    in_nan,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES*(1+EXP_W+MANT_W)-1:0]   out_data,
    input  logic                                flags_clr,
    output logic                                flag_ovf,
    output logic                                flag_unf,
    output logic                                flag_inx,
    output logic                                flag_nan
);

    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int XW = EXP_W + 2;
    localparam int MW = MANT_W + 3;

    logic                   stall;
    logic                   out_fire;

    logic                   s1_valid;
    logic                   s1_rnd;
    logic [LANES-1:0]       s1_sign;
    logic [LANES*XW-1:0]    s1_exp;
    logic [LANES*MW-1:0]    s1_mant;
    logic [LANES-1:0]       s1_zero;
    logic [LANES-1:0]       s1_inf;
    logic [LANES-1:0]       s1_nan;

    logic [LANES*W-1:0]     lane_word;
    logic [LANES-1:0]       lane_ovf;
    logic [LANES-1:0]       lane_unf;
    logic [LANES-1:0]       lane_inx;
    logic [LANES-1:0]       lane_nan;

    logic                   s2_ovf;
    logic                   s2_unf;
    logic                   s2_inx;
    logic                   s2_nan;

    // Whole pipeline moves in lockstep, so bubbles stay where they are.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign out_fire = out_valid & out_ready;

    // Stage valid bits: cleared by reset, advance together when not stalled.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every stage
        // samples the pre-edge value of the stage before it.
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
        end
    end

    // S1 payload capture on an accepted input beat.
    always_ff @(posedge clk) begin
        // NOTE: the S1 payload carries no reset; s1_valid qualifies it, so
        // stale contents never reach the output.
        if (in_valid && in_ready) begin
            s1_rnd  <= rnd_mode;
            s1_sign <= in_sign;
            s1_exp  <= in_exp;
            s1_mant <= in_mant;
            s1_zero <= in_zero;
            s1_inf  <= in_inf;
            s1_nan  <= in_nan;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_round_lane #(
            .EXP_W  (EXP_W),
            .MANT_W (MANT_W)
        ) u_lane (
            .rnd_mode (s1_rnd),
            .sign     (s1_sign[i]),
            .exp      (s1_exp[i*XW +: XW]),
            .mant     (s1_mant[i*MW +: MW]),
            .zero     (s1_zero[i]),
            .inf      (s1_inf[i]),
            .nan      (s1_nan[i]),
            .word     (lane_word[i*W +: W]),
            .set_ovf  (lane_ovf[i]),
            .set_unf  (lane_unf[i]),
            .set_inx  (lane_inx[i]),
            .set_nan  (lane_nan[i])
        );
    end

    // S2: packed words plus the lane-ORed exceptions of the same beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
            s2_inx   <= 1'b0;
            s2_nan   <= 1'b0;
        end else if (!stall && s1_valid) begin
            out_data <= lane_word;
            s2_ovf   <= |lane_ovf;
            s2_unf   <= |lane_unf;
            s2_inx   <= |lane_inx;
            s2_nan   <= |lane_nan;
        end
    end

    // Sticky flags: clear first, then OR in the handshaking beat so a set
    // in the same cycle as a clear survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
            flag_nan <= 1'b0;
        end else begin
            flag_ovf <= (flag_ovf & ~flags_clr) | (out_fire & s2_ovf);
            flag_unf <= (flag_unf & ~flags_clr) | (out_fire & s2_unf);
            flag_inx <= (flag_inx & ~flags_clr) | (out_fire & s2_inx);
            flag_nan <= (flag_nan & ~flags_clr) | (out_fire & s2_nan);
        end
    end

endmodule

// File: tb/tb_fp_pack_round_pipe.sv
// Directed-vector bench for fp_pack_round_pipe (EXP_W=8, MANT_W=23, LANES=4).
// Expected words are hand-computed single-precision encodings.
module tb_fp_pack_round_pipe;
    import fp_pack_pkg::*;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int LANES  = 4;
    localparam int XW     = EXP_W + 2;
    localparam int MW     = MANT_W + 3;
    localparam int W      = 1 + EXP_W + MANT_W;

    localparam int K_NUM  = 0;
    localparam int K_ZERO = 1;
    localparam int K_INF  = 2;
    localparam int K_NAN  = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic                  rnd_mode;
    logic [LANES-1:0]      in_sign;
    logic [LANES*XW-1:0]   in_exp;
    logic [LANES*MW-1:0]   in_mant;
    logic [LANES-1:0]      in_zero;
    logic [LANES-1:0]      in_inf;
    logic [LANES-1:0]      in_nan;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*W-1:0]    out_data;
    logic                  flags_clr;
    logic                  flag_ovf;
    logic                  flag_unf;
    logic                  flag_inx;
    logic                  flag_nan;

    int n_vec  = 0;
    int n_miss = 0;
    int bp_stalled;
    int bp_got;
    int wait_n;

    always #5 clk = ~clk;

    fp_pack_round_pipe #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .LANES  (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rnd_mode  (rnd_mode),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_zero   (in_zero),
        .in_inf    (in_inf),
        .in_nan    (in_nan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flags_clr (flags_clr),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx),
        .flag_nan  (flag_nan)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic [MANT_W-1:0] frac, input logic g, input logic s);
        return {1'b1, frac, g, s};
    endfunction

    task automatic set_lane(input int i, input int kind, input logic sg,
                            input logic [XW-1:0] e, input logic [MW-1:0] m);
        in_sign[i]          = sg;
        in_exp[i*XW +: XW]  = e;
        in_mant[i*MW +: MW] = m;
        in_zero[i]          = (kind == K_ZERO);
        in_inf[i]           = (kind == K_INF);
        in_nan[i]           = (kind == K_NAN);
    endtask

    task automatic clr_lanes();
        for (int i = 0; i < LANES; i++) set_lane(i, K_ZERO, 1'b0, '0, '0);
    endtask

    // One beat with out_ready high: drive, wait two edges, compare at the
    // negedge where the beat sits in S2, optionally pulse flags_clr there.
    task automatic run_beat(input string tag, input logic rnd, input logic clr_on_out,
                            input logic [127:0] want);
        @(negedge clk);
        rnd_mode = rnd;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".valid"}, out_valid, 1'b1);
        for (int i = 0; i < LANES; i++)
            check($sformatf("%s.lane%0d", tag, i), out_data[i*W +: W], want[i*W +: W]);
        if (clr_on_out) flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic o, input logic u,
                               input logic x, input logic n);
        check({tag, ".ovf"}, flag_ovf, o);
        check({tag, ".unf"}, flag_unf, u);
        check({tag, ".inx"}, flag_inx, x);
        check({tag, ".nan"}, flag_nan, n);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
    endtask

    // Backpressure beats: lane0 exact positive, lane1 exact negative, rest zero.
    task automatic bp_lanes(input int k);
        clr_lanes();
        set_lane(0, K_NUM, 1'b0, XW'(127 + k), mk(MANT_W'(k + 1), 1'b0, 1'b0));
        set_lane(1, K_NUM, 1'b1, XW'(100 + k), mk(MANT_W'(k * 3), 1'b0, 1'b0));
    endtask

    function automatic logic [127:0] bp_word(input int k);
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = {1'b0, 8'(127 + k), 23'(k + 1)};
        w1 = {1'b1, 8'(100 + k), 23'(k * 3)};
        return {64'h0, w1, w0};
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        rnd_mode  = RND_RNE;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        clr_lanes();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.out_data", out_data, '0);
        check("reset.in_ready", in_ready, 1'b1);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // A: RNE carry, tie-to-even, NaN, -inf
        clr_lanes();
        set_lane(0, K_NUM, 1'b0, 10'd127, mk(23'h7FFFFF, 1'b1, 1'b0));
        set_lane(1, K_NUM, 1'b0, 10'd127, mk(23'h000000, 1'b1, 1'b0));
        set_lane(2, K_NAN, 1'b1, 10'd0,   '0);
        set_lane(3, K_INF, 1'b1, 10'd0,   '0);
        run_beat("A", RND_RNE, 1'b0, {32'hFF800000, 32'h7FC00000, 32'h3F800000, 32'h40000000});
        check_flags("A", 1'b0, 1'b0, 1'b1, 1'b1);
        clear_flags();
        check_flags("clrA", 1'b0, 1'b0, 1'b0, 1'b0);

        // B: RTZ tie, RTZ overflow to max finite, -0 special, exp=0 flush
        clr_lanes();
        set_lane(0, K_NUM,  1'b0, 10'd127, mk(23'h000000, 1'b1, 1'b0));
        set_lane(1, K_NUM,  1'b0, 10'd255, mk(23'h000000, 1'b0, 1'b0));
        set_lane(2, K_ZERO, 1'b1, 10'd0,   '0);
        set_lane(3, K_NUM,  1'b1, 10'd0,   mk(23'h000000, 1'b0, 1'b0));
        run_beat("B", RND_RTZ, 1'b0, {32'h80000000, 32'h80000000, 32'h7F7FFFFF, 32'h3F800000});
        check_flags("B", 1'b1, 1'b1, 1'b1, 1'b0);
        clear_flags();

        // C: RNE overflow via carry, negative exp, round up out of underflow, odd-lsb tie
        clr_lanes();
        set_lane(0, K_NUM, 1'b0, 10'd254,  mk(23'h7FFFFF, 1'b1, 1'b0));
        set_lane(1, K_NUM, 1'b0, 10'h3FD,  mk(23'h000000, 1'b0, 1'b0));
        set_lane(2, K_NUM, 1'b0, 10'd0,    mk(23'h7FFFFF, 1'b1, 1'b0));
        set_lane(3, K_NUM, 1'b0, 10'd128,  mk(23'h000001, 1'b1, 1'b0));
        run_beat("C", RND_RNE, 1'b0, {32'h40000002, 32'h00800000, 32'h00000000, 32'h7F800000});
        check_flags("C", 1'b1, 1'b1, 1'b1, 1'b0);
        clear_flags();

        // D: exact values at the range edges raise nothing
        clr_lanes();
        set_lane(0, K_NUM, 1'b0, 10'd127, mk(23'h000000, 1'b0, 1'b0));
        set_lane(1, K_NUM, 1'b0, 10'd254, mk(23'h7FFFFF, 1'b0, 1'b0));
        set_lane(2, K_NUM, 1'b0, 10'd1,   mk(23'h000000, 1'b0, 1'b0));
        set_lane(3, K_NUM, 1'b1, 10'd130, mk(23'h123456, 1'b0, 1'b0));
        run_beat("D", RND_RNE, 1'b0, {32'hC1123456, 32'h00800000, 32'h7F7FFFFF, 32'h3F800000});
        check_flags("D", 1'b0, 1'b0, 1'b0, 1'b0);

        // E: RTZ truncation never carries; exp=0 still flushes
        clr_lanes();
        set_lane(0, K_NUM, 1'b0, 10'd254, mk(23'h7FFFFF, 1'b1, 1'b0));
        set_lane(1, K_NUM, 1'b0, 10'd127, mk(23'h7FFFFF, 1'b1, 1'b1));
        set_lane(2, K_NUM, 1'b0, 10'd1,   mk(23'h000000, 1'b1, 1'b0));
        set_lane(3, K_NUM, 1'b1, 10'd0,   mk(23'h7FFFFF, 1'b1, 1'b1));
        run_beat("E", RND_RTZ, 1'b0, {32'h80000000, 32'h00800000, 32'h3FFFFFFF, 32'h7F7FFFFF});
        check_flags("E", 1'b0, 1'b1, 1'b1, 1'b0);

        // F then G: clear coinciding with an overflow handshake
        clr_lanes();
        set_lane(0, K_NUM, 1'b0, 10'd0, mk(23'h000000, 1'b0, 1'b0));
        run_beat("F", RND_RNE, 1'b0, {96'h0, 32'h00000000});
        check_flags("F", 1'b0, 1'b1, 1'b1, 1'b0);
        clr_lanes();
        set_lane(0, K_NUM, 1'b0, 10'd255, mk(23'h000000, 1'b0, 1'b0));
        run_beat("G", RND_RNE, 1'b1, {96'h0, 32'h7F800000});
        check_flags("G", 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure: three back-to-back beats, output held off five cycles
        out_ready  = 1'b0;
        bp_stalled = 0;
        bp_got     = 0;
        @(negedge clk);
        fork
            begin
                rnd_mode = RND_RNE;
                for (int k = 0; k < 3; k++) begin
                    bp_lanes(k);
                    in_valid = 1'b1;
                    wait_n   = 0;
                    while (!in_ready && wait_n < 20) begin
                        @(negedge clk);
                        wait_n++;
                    end
                    check($sformatf("bp.accept%0d", k), in_ready, 1'b1);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 40; cyc++) begin
                    @(negedge clk);
                    if (out_valid && !out_ready) begin
                        check("bp.in_ready_low", in_ready, 1'b0);
                        bp_stalled++;
                    end
                    if (out_valid && out_ready) begin
                        if (bp_got < 3)
                            check($sformatf("bp.beat%0d", bp_got), out_data, bp_word(bp_got));
                        bp_got++;
                    end
                    @(posedge clk);
                    #1 out_ready = (bp_stalled >= 5);
                end
            end
        join
        check("bp.count", bp_got, 3);
        check("bp.stall_cycles", bp_stalled, 5);

        // Reset while stalled with beats in both stages
        out_ready = 1'b0;
        @(negedge clk);
        bp_lanes(5);
        in_valid = 1'b1;
        @(negedge clk);
        bp_lanes(6);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst.pre_valid", out_valid, 1'b1);
        check("rst.pre_in_ready", in_ready, 1'b0);
        check("rst.pre_ovf", flag_ovf, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst.out_valid", out_valid, 1'b0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst.dropped%0d", c), out_valid, 1'b0);
        end
        check("rst.in_ready", in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
